writeback: RTL

WRITEBACK -- requirements
Module: writeback

---
 rtl/writeback.sv | 128 ++++++++++++
 1 files changed

// File: rtl/writeback.sv
// Writeback stage: buffers register writes in a small in-order FIFO, counts
// retired instructions and halts the core after draining on an exception.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALEN
`define ALEN 32
`endif

module writeback #(
  parameter int INSTRET_WIDTH = 64,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     prev_stalled,
  output logic                     stall_prev,
  input  logic                     exec_exception,
  input  logic                     exec_is_reg_write,
  input  logic [4:0]               exec_reg_write_sel,
  input  logic [`XLEN-1:0]         exec_result,
  input  logic [`ALEN-1:0]         exec_instruction_next_addr,
  input  logic                     regfile_wr_ready,
  output logic                     reg_write_valid,
  output logic [4:0]               reg_write_sel,
  output logic [`XLEN-1:0]         reg_write_data,
  output logic [INSTRET_WIDTH-1:0] instret,
  output logic [`ALEN-1:0]         retire_next_addr,
  output logic [`ALEN-1:0]         trap_addr,
  output logic                     halted
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [INSTRET_WIDTH-1:0] instret_q, instret_d;
  logic [`ALEN-1:0]         retire_next_addr_q, retire_next_addr_d;
  logic [`ALEN-1:0]         trap_addr_q, trap_addr_d;

  logic [4:0]               fifo_sel_q  [FIFO_DEPTH];
  logic [`XLEN-1:0]         fifo_data_q [FIFO_DEPTH];

  logic accept, push, pop;

  always_comb begin
    state_d            = state_q;
    count_d            = count_q;
    wr_ptr_d           = wr_ptr_q;
    rd_ptr_d           = rd_ptr_q;
    instret_d          = instret_q;
    retire_next_addr_d = retire_next_addr_q;
    trap_addr_d        = trap_addr_q;

    stall_prev = (count_q == FULL) || (state_q != RUN);
    accept     = !prev_stalled && !stall_prev;
    push       = accept && !exec_exception && exec_is_reg_write &&
                 (exec_reg_write_sel != 5'd0);
    pop        = (count_q != '0) && regfile_wr_ready;

    if (accept) begin
      retire_next_addr_d = exec_instruction_next_addr;
      if (exec_exception) begin
        trap_addr_d = exec_instruction_next_addr;
        state_d     = DRAIN;
      end else begin
        instret_d = instret_q + INSTRET_WIDTH'(1);
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase

    // Halt once the last pending write leaves (or nothing was pending).
    if (state_q == DRAIN && (count_q == '0 || (count_q == ONE && pop)))
      state_d = HALTED;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q            <= RUN;
      count_q            <= '0;
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      instret_q          <= '0;
      retire_next_addr_q <= '0;
      trap_addr_q        <= '0;
    end else begin
      state_q            <= state_d;
      count_q            <= count_d;
      wr_ptr_q           <= wr_ptr_d;
      rd_ptr_q           <= rd_ptr_d;
      instret_q          <= instret_d;
      retire_next_addr_q <= retire_next_addr_d;
      trap_addr_q        <= trap_addr_d;
    end
  end

  // Entry storage needs no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_sel_q[wr_ptr_q]  <= exec_reg_write_sel;
      fifo_data_q[wr_ptr_q] <= exec_result;
    end
  end

  assign reg_write_valid  = (count_q != '0);
  assign reg_write_sel    = fifo_sel_q[rd_ptr_q];
  assign reg_write_data   = fifo_data_q[rd_ptr_q];
  assign instret          = instret_q;
  assign retire_next_addr = retire_next_addr_q;
  assign trap_addr        = trap_addr_q;
  assign halted           = (state_q == HALTED);

endmodule
